regfile_scoreboard: RTL

Issue-side scheduler and write-port arbiter for the 32 x 64-bit register file. It tracks which architectural registers have an in-flight write and stalls issue on RAW and WAW hazards. It also merges two writeback sources, ALU and MEM, onto the register file's single write port. It sits between decode/issue and the register file, and it alone drives the file's regWrite/writeReg/dataWrite inputs.

---
 rtl/regfile_scoreboard.sv | 130 +++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Issue-side hazard scoreboard and writeback arbiter for the 32 x WIDTH
// register file. It keeps one busy bit per architectural register. Issue is
// stalled on RAW and WAW hazards. ALU and MEM writebacks are merged onto the
// single registered write port, with round-robin arbitration on conflict.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   issue_*                    decoded instruction (sources, dest, valid)
//   issue_ready                no hazard: instruction may issue this cycle
//   alu_wb_*, mem_wb_*         writeback requests (valid/rd/data)
//   alu_wb_ready, mem_wb_ready grant for this cycle
//   rf_regWrite/writeReg/dataWrite  registered register file write port
//   busy_mask                  scoreboard state (bit 0 always 0)
//   wb_err                     sticky: writeback to a non-busy register
module regfile_scoreboard #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned NREG  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rs1,
  input  logic [4:0]       issue_rs2,
  input  logic             issue_use_rs1,
  input  logic             issue_use_rs2,
  input  logic [4:0]       issue_rd,
  input  logic             issue_wr,
  output logic             issue_ready,
  input  logic             alu_wb_valid,
  input  logic [4:0]       alu_wb_rd,
  input  logic [WIDTH-1:0] alu_wb_data,
  output logic             alu_wb_ready,
  input  logic             mem_wb_valid,
  input  logic [4:0]       mem_wb_rd,
  input  logic [WIDTH-1:0] mem_wb_data,
  output logic             mem_wb_ready,
  output logic             rf_regWrite,
  output logic [4:0]       rf_writeReg,
  output logic [WIDTH-1:0] rf_dataWrite,
  output logic [NREG-1:0]  busy_mask,
  output logic             wb_err
);

  typedef enum logic {
    RR_ALU = 1'b0,
    RR_MEM = 1'b1
  } rr_e;

  logic [NREG-1:0]  busy_q, busy_d;
  rr_e              rr_q, rr_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_rd_q, rf_rd_d;
  logic [WIDTH-1:0] rf_data_q, rf_data_d;
  logic             wb_err_q, wb_err_d;

  logic             conflict;
  logic             alu_gnt, mem_gnt;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;

  always_comb begin
    issue_ready = !reset
                  && !(issue_use_rs1 && busy_q[issue_rs1])
                  && !(issue_use_rs2 && busy_q[issue_rs2])
                  && !(issue_wr      && busy_q[issue_rd]);

    conflict = alu_wb_valid && mem_wb_valid;
    alu_gnt  = !reset && alu_wb_valid && (!mem_wb_valid || rr_q == RR_ALU);
    mem_gnt  = !reset && mem_wb_valid && (!alu_wb_valid || rr_q == RR_MEM);
    alu_wb_ready = alu_gnt;
    mem_wb_ready = mem_gnt;

    wb_rd   = mem_gnt ? mem_wb_rd   : alu_wb_rd;
    wb_data = mem_gnt ? mem_wb_data : alu_wb_data;

    rr_d = rr_q;
    if (conflict) begin
      rr_d = (rr_q == RR_ALU) ? RR_MEM : RR_ALU;
    end

    // Write index/data hold their last value when no write is presented;
    // only rf_regWrite qualifies them.
    rf_we_d   = (alu_gnt || mem_gnt) && (wb_rd != '0);
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (rf_we_d) begin
      rf_rd_d   = wb_rd;
      rf_data_d = wb_data;
    end

    wb_err_d = wb_err_q || (rf_we_d && !busy_q[wb_rd]);

    // Clear for the write being presented now, then set for a new issue, so
    // a same-register collision leaves the bit set.
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_rd_q] = 1'b0;
    end
    if (issue_valid && issue_ready && issue_wr && issue_rd != '0) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q    <= '0;
      rr_q      <= RR_MEM;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      rr_q      <= rr_d;
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign rf_regWrite  = rf_we_q;
  assign rf_writeReg  = rf_rd_q;
  assign rf_dataWrite = rf_data_q;
  assign busy_mask    = busy_q;
  assign wb_err       = wb_err_q;

endmodule
